// File: rtl/raystore_alloc.sv
`default_nettype none
// ============================================================================
// Module   : raystore_alloc
// Purpose  : Allocates rayIDs for incoming rays, writes them to the raystore
//            and notifies traversal once the write has landed.
//            Optional define RS_WR_THROTTLE_EN spaces raystore writes by GAP.
// Revision : 1.0 - initial release
// ============================================================================
module raystore_alloc #(
    parameter int NUM_RAYS = 512,
    parameter int ID_W     = 9,
    parameter int GAP      = 3,
    parameter int DATA_W   = 192  // packed ray origin + direction (ray_vec_t)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              raygen_valid,
    input  logic [DATA_W-1:0] raygen_data,
    output logic              raygen_stall,
    input  logic              ray_free_valid,
    input  logic [ID_W-1:0]   ray_free_id,
    output logic              raystore_we,
    output logic [ID_W-1:0]   raystore_write_addr,
    output logic [DATA_W-1:0] raystore_write_data,
    output logic              rs_alloc_valid,
    output logic [ID_W-1:0]   rs_alloc_rayID,
    input  logic              rs_alloc_stall,
    output logic [ID_W:0]     num_free,
    output logic              free_err
);

    localparam logic [ID_W:0]   c_NUM  = (ID_W+1)'(NUM_RAYS);
    localparam logic [ID_W:0]   c_ONE  = (ID_W+1)'(1);
    localparam logic [ID_W-1:0] c_LAST = ID_W'(NUM_RAYS - 1);

    logic [ID_W:0]     fc_q, fc_d;
    logic [ID_W-1:0]   ff_mem [NUM_RAYS];
    logic [ID_W-1:0]   ff_rd_q, ff_rd_d;
    logic [ID_W-1:0]   ff_wr_q, ff_wr_d;
    logic [ID_W:0]     num_free_q, num_free_d;
    logic              free_err_q, free_err_d;

    logic              we_q;
    logic [ID_W-1:0]   addr_q;
    logic [DATA_W-1:0] data_q;

    logic [ID_W-1:0]   nf_mem_q [2];
    logic              nf_rd_q;
    logic              nf_wr_q;
    logic [1:0]        nf_cnt_q;

    logic              w_fresh;
    logic              w_nf_pop;
    logic [2:0]        w_nf_occ;
    logic              w_throttle;
    logic              w_block;
    logic              w_accept;
    logic              w_free_ok;
    logic [ID_W-1:0]   w_alloc_id;

    function automatic logic [ID_W-1:0] f_next(input logic [ID_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_fresh  = (fc_q != c_NUM);
    assign w_nf_pop = (nf_cnt_q != 2'd0) & ~rs_alloc_stall;
    // Occupancy is taken net of this cycle's pop so a draining consumer
    // sustains one accept per cycle while never overflowing the 2 entries.
    assign w_nf_occ = {1'b0, nf_cnt_q} + {2'b00, we_q} - {2'b00, w_nf_pop};

    assign w_block      = (num_free_q == '0) | (w_nf_occ >= 3'd2) | w_throttle;
    assign raygen_stall = raygen_valid & w_block;
    assign w_accept     = raygen_valid & ~w_block;
    assign w_free_ok    = ray_free_valid & (num_free_q != c_NUM);
    assign w_alloc_id   = w_fresh ? fc_q[ID_W-1:0] : ff_mem[ff_rd_q];

`ifdef RS_WR_THROTTLE_EN
    localparam int c_THR_W = (GAP < 1) ? 1 : $clog2(GAP + 1);
    logic [c_THR_W-1:0] thr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q <= '0;
        end else if (w_accept) begin
            thr_q <= c_THR_W'(GAP);
        end else if (thr_q != '0) begin
            thr_q <= thr_q - 1'b1;
        end
    end

    assign w_throttle = (thr_q != '0);
`else
    logic [31:0] unused_gap;
    assign unused_gap = GAP;
    assign w_throttle = 1'b0;
`endif

    always_comb begin
        fc_d       = fc_q;
        ff_rd_d    = ff_rd_q;
        ff_wr_d    = ff_wr_q;
        num_free_d = num_free_q;
        free_err_d = free_err_q | (ray_free_valid & ~w_free_ok);
        if (w_accept) begin
            if (w_fresh) begin
                fc_d = fc_q + c_ONE;
            end else begin
                ff_rd_d = f_next(ff_rd_q);
            end
        end
        if (w_free_ok) begin
            ff_wr_d = f_next(ff_wr_q);
        end
        case ({w_accept, w_free_ok})
            2'b10:   num_free_d = num_free_q - c_ONE;
            2'b01:   num_free_d = num_free_q + c_ONE;
            default: num_free_d = num_free_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fc_q       <= '0;
            ff_rd_q    <= '0;
            ff_wr_q    <= '0;
            num_free_q <= c_NUM;
            free_err_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            nf_rd_q    <= 1'b0;
            nf_wr_q    <= 1'b0;
            nf_cnt_q   <= 2'd0;
        end else begin
            fc_q       <= fc_d;
            ff_rd_q    <= ff_rd_d;
            ff_wr_q    <= ff_wr_d;
            num_free_q <= num_free_d;
            free_err_q <= free_err_d;
            we_q       <= w_accept;
            if (w_accept) begin
                addr_q <= w_alloc_id;
                data_q <= raygen_data;
            end
            // The ID written last cycle is now safe to announce.
            if (we_q) begin
                nf_wr_q <= ~nf_wr_q;
            end
            if (w_nf_pop) begin
                nf_rd_q <= ~nf_rd_q;
            end
            nf_cnt_q <= nf_cnt_q + {1'b0, we_q} - {1'b0, w_nf_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_free_ok) begin
            ff_mem[ff_wr_q] <= ray_free_id;
        end
        if (we_q) begin
            nf_mem_q[nf_wr_q] <= addr_q;
        end
    end

    assign raystore_we         = we_q;
    assign raystore_write_addr = addr_q;
    assign raystore_write_data = data_q;
    assign rs_alloc_valid      = (nf_cnt_q != 2'd0);
    assign rs_alloc_rayID      = nf_mem_q[nf_rd_q];
    assign num_free            = num_free_q;
    assign free_err            = free_err_q;

endmodule
`default_nettype wire

// File: tb/tb_raystore_alloc.sv
`default_nettype none
// Randomized scoreboard bench for raystore_alloc against a queue-based model
// of the rayID pool and the write/notify pipeline.
module tb_raystore_alloc;

    localparam int NUM = 512;
    localparam int IDW = 9;
    localparam int GAP = 3;
    localparam int DW  = 192;

    logic           clk = 1'b0;
    logic           rst;
    logic           raygen_valid;
    logic [DW-1:0]  raygen_data;
    logic           raygen_stall;
    logic           ray_free_valid;
    logic [IDW-1:0] ray_free_id;
    logic           raystore_we;
    logic [IDW-1:0] raystore_write_addr;
    logic [DW-1:0]  raystore_write_data;
    logic           rs_alloc_valid;
    logic [IDW-1:0] rs_alloc_rayID;
    logic           rs_alloc_stall;
    logic [IDW:0]   num_free;
    logic           free_err;

    always #5 clk = ~clk;

    raystore_alloc #(
        .NUM_RAYS (NUM),
        .ID_W     (IDW),
        .GAP      (GAP),
        .DATA_W   (DW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .raygen_valid        (raygen_valid),
        .raygen_data         (raygen_data),
        .raygen_stall        (raygen_stall),
        .ray_free_valid      (ray_free_valid),
        .ray_free_id         (ray_free_id),
        .raystore_we         (raystore_we),
        .raystore_write_addr (raystore_write_addr),
        .raystore_write_data (raystore_write_data),
        .rs_alloc_valid      (rs_alloc_valid),
        .rs_alloc_rayID      (rs_alloc_rayID),
        .rs_alloc_stall      (rs_alloc_stall),
        .num_free            (num_free),
        .free_err            (free_err)
    );

    typedef struct { int cyc; int id; logic [DW-1:0] data; } wr_t;
    typedef struct { int cyc; int id; } nt_t;

    wr_t           exp_wr[$];
    nt_t           exp_nt[$];
    int            pool[$];
    int            live[$];
    int            nfcnt    = 0;
    bit            inflight = 0;
    bit            m_err    = 0;
    int            last_acc = -1000;
    int            cyc      = 0;
    logic [IDW-1:0] last_addr = '0;
    logic [DW-1:0]  last_data = '0;
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pool.delete();
        for (int i = 0; i < NUM; i++) pool.push_back(i);
        live.delete();
        exp_wr.delete();
        exp_nt.delete();
        nfcnt     = 0;
        inflight  = 0;
        m_err     = 0;
        last_acc  = -1000;
        last_addr = '0;
        last_data = '0;
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b1;
        raygen_valid   = 1'b0;
        ray_free_valid = 1'b0;
        rs_alloc_stall = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        model_reset();
        for (int i = 1; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model.
    task automatic step(input bit v, input bit fv, input int fid, input bit as);
        logic [DW-1:0] d;
        bit pop, blk, acc, full_pre, thr;
        int id;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        raygen_valid   = v;
        raygen_data    = d;
        ray_free_valid = fv;
        ray_free_id    = IDW'(fid);
        rs_alloc_stall = as;
        #1;
        thr = 1'b0;
`ifdef RS_WR_THROTTLE_EN
        thr = (cyc - last_acc) <= GAP;
`endif
        pop = (nfcnt > 0) && !as;
        blk = (pool.size() == 0) || ((nfcnt - int'(pop) + int'(inflight)) >= 2) || thr;
        chk("raygen_stall", raygen_stall, v && blk);
        chk("num_free", num_free, pool.size());
        chk("rs_alloc_valid", rs_alloc_valid, nfcnt > 0);
        chk("free_err", free_err, m_err);
        full_pre = (pool.size() == NUM);
        acc = v && !blk;
        if (acc) begin
            id = pool.pop_front();
            exp_wr.push_back('{cyc + 1, id, d});
            exp_nt.push_back('{cyc + 2, id});
            live.push_back(id);
            last_acc = cyc;
        end
        if (fv) begin
            if (full_pre) m_err = 1'b1;
            else pool.push_back(fid);
        end
        nfcnt    = nfcnt - int'(pop) + int'(inflight);
        inflight = acc;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic free_live(input int id, output bit found);
        found = 1'b0;
        for (int k = 0; k < live.size(); k++) begin
            if (!found && live[k] == id) begin
                live.delete(k);
                found = 1'b1;
            end
        end
    endtask

    // Monitor: retires expected writes and notifications as the DUT shows them.
    initial begin : monitor
        wr_t            e;
        bit             held;
        logic [IDW-1:0] held_id;
        held    = 1'b0;
        held_id = '0;
        forever begin
            @(negedge clk);
            if (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
                e = exp_wr.pop_front();
                chk("wr_strobe", raystore_we, 1'b1);
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", raystore_write_addr, e.id);
                chk("wr_data", raystore_write_data, e.data);
                last_addr = IDW'(e.id);
                last_data = e.data;
            end else begin
                chk("wr_idle", raystore_we, 1'b0);
                chk("wr_addr_hold", raystore_write_addr, last_addr);
                chk("wr_data_hold", raystore_write_data, last_data);
            end
            if (rs_alloc_valid) begin
                if (held) chk("rayID_stable", rs_alloc_rayID, held_id);
                if (exp_nt.size() == 0) begin
                    chk("unexpected_notify", rs_alloc_valid, 1'b0);
                end else begin
                    chk("notify_id", rs_alloc_rayID, exp_nt[0].id);
                    if (cyc < exp_nt[0].cyc) chk("notify_early", cyc, exp_nt[0].cyc);
                    if (!rs_alloc_stall) void'(exp_nt.pop_front());
                end
                held    = rs_alloc_stall;
                held_id = rs_alloc_rayID;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin : driver
        bit v, fv, as, found;
        int fid, k, n;
        raygen_data = '0;
        ray_free_id = '0;
        do_reset(3);

        chk("rst_num_free", num_free, NUM);
        chk("rst_alloc_valid", rs_alloc_valid, 1'b0);
        chk("rst_we", raystore_we, 1'b0);
        chk("rst_addr", raystore_write_addr, 0);
        chk("rst_data", raystore_write_data, 0);
        chk("rst_free_err", free_err, 1'b0);

        // Bogus free while every ID is free: sticky error, count unchanged.
        step(1'b0, 1'b1, 5, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);

        repeat (20) step(1'b1, 1'b0, 0, 1'b0);
        repeat (8)  step(1'b1, 1'b0, 0, 1'b1);
        repeat (6)  step(1'b0, 1'b0, 0, 1'b0);

        // Randomized mix of accepts, frees and downstream back-pressure.
        repeat (1500) begin
            v   = ($urandom_range(0, 3) != 0);
            fv  = (live.size() > 0) && ($urandom_range(0, 3) == 0);
            fid = 0;
            if (fv) begin
                k   = $urandom_range(0, live.size() - 1);
                fid = live[k];
                live.delete(k);
            end
            as = ($urandom_range(0, 2) == 0);
            step(v, fv, fid, as);
        end

        // Exhaust the pool, then return ID 37.
        do_reset(2);
        n = 0;
        while (pool.size() > 0 && n < 5000) begin
            step(1'b1, 1'b0, 0, 1'b0);
            n++;
        end
        chk("pool_exhausted", num_free, 0);
        repeat (4) step(1'b1, 1'b0, 0, 1'b0);
        free_live(37, found);
        step(1'b1, 1'b1, 37, 1'b0);
        repeat (6) step(1'b1, 1'b0, 0, 1'b0);

        // Reset the cycle after an accept: nothing must follow.
        do_reset(2);
        step(1'b1, 1'b0, 0, 1'b0);
        do_reset(1);
        repeat (6) step(1'b0, 1'b0, 0, 1'b0);

        repeat (8) step(1'b0, 1'b0, 0, 1'b0);
        chk("writes_drained", exp_wr.size(), 0);
        chk("notifies_drained", exp_nt.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
